// File: rtl/regfile_pkg.sv
// Shared types and helpers for the paired register file with increment/decrement unit.
package regfile_pkg;

  // IDU sequencer states; LO/HI are the byte-serial path, ONE the single-cycle path.
  typedef enum logic [1:0] {
    IDU_IDLE = 2'd0,
    IDU_LO   = 2'd1,
    IDU_HI   = 2'd2,
    IDU_ONE  = 2'd3
  } idu_state_t;

  // Largest pair value at the default 8-bit register width; +1 from here wraps to zero.
  localparam int unsigned IDU_WRAP_MAX = 32'h0000_FFFF;

  // Register index of the high byte of pair p.
  function automatic int unsigned hi_idx(input int unsigned p);
    return 2 * p;
  endfunction

  // Register index of the low byte of pair p.
  function automatic int unsigned lo_idx(input int unsigned p);
    return 2 * p + 1;
  endfunction

endpackage

// File: rtl/regfile_idu_fsm.sv
// Pair increment/decrement sequencer: captures the pair at request, then writes
// lo and hi bytes back (byte-serial) or the whole pair at once (single-cycle).
module regfile_idu_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned PAW       = 2,
  parameter int unsigned IDU_SPLIT = 1,
  localparam int unsigned PW       = 2 * DW
) (
  input  logic           clk,
  input  logic           nres,
  input  logic           idu_req,
  input  logic [PAW-1:0] idu_sel,
  input  logic           idu_dec,
  input  logic [PW-1:0]  pair_val_c,
  output logic           idu_busy,
  output logic           idu_done,
  output logic [PW-1:0]  idu_addr,
  output logic           idu_wrap,
  output logic [PAW-1:0] wb_sel,
  output logic           hi_we_c,
  output logic           lo_we_c,
  output logic [DW-1:0]  hi_data_c,
  output logic [DW-1:0]  lo_data_c
);

  idu_state_t state_q, state_d;
  logic       dec_q;
  logic       carry_q, carry_d;
  logic       wrap_d;
  logic [DW-1:0] addr_hi, addr_lo;
  logic       lo_carry_c, full_wrap_c;
  logic [PW-1:0] pair_step_c;

  // Arithmetic always works on the captured value so external writes cannot perturb it.
  assign addr_hi     = idu_addr[PW-1:DW];
  assign addr_lo     = idu_addr[DW-1:0];
  assign lo_carry_c  = dec_q ? (addr_lo == '0) : (addr_lo == '1);
  assign full_wrap_c = dec_q ? (idu_addr == '0) : (idu_addr == '1);
  assign pair_step_c = dec_q ? (idu_addr - PW'(1)) : (idu_addr + PW'(1));

  // Next state, carry and writeback strobes.
  always_comb begin
    state_d   = state_q;
    carry_d   = carry_q;
    wrap_d    = idu_wrap;
    hi_we_c   = 1'b0;
    lo_we_c   = 1'b0;
    hi_data_c = '0;
    lo_data_c = '0;
    unique case (state_q)
      IDU_IDLE: begin
        if (idu_req) state_d = (IDU_SPLIT != 0) ? IDU_LO : IDU_ONE;
      end
      IDU_LO: begin
        lo_we_c   = 1'b1;
        lo_data_c = dec_q ? (addr_lo - DW'(1)) : (addr_lo + DW'(1));
        carry_d   = lo_carry_c;
        state_d   = IDU_HI;
      end
      IDU_HI: begin
        hi_we_c   = 1'b1;
        hi_data_c = dec_q ? (addr_hi - DW'(carry_q)) : (addr_hi + DW'(carry_q));
        wrap_d    = full_wrap_c;
        state_d   = IDU_IDLE;
      end
      IDU_ONE: begin
        hi_we_c   = 1'b1;
        lo_we_c   = 1'b1;
        hi_data_c = pair_step_c[PW-1:DW];
        lo_data_c = pair_step_c[DW-1:0];
        wrap_d    = full_wrap_c;
        state_d   = IDU_IDLE;
      end
      default: state_d = IDU_IDLE;
    endcase
  end

  // State, status flags and request capture.
  always_ff @(posedge clk) begin
    if (!nres) begin
      state_q  <= IDU_IDLE;
      idu_busy <= 1'b0;
      idu_done <= 1'b0;
      idu_wrap <= 1'b0;
      idu_addr <= '0;
      wb_sel   <= '0;
      dec_q    <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idu_busy <= (state_d != IDU_IDLE);
      idu_done <= (state_d == IDU_HI) || (state_d == IDU_ONE);
      idu_wrap <= wrap_d;
      carry_q  <= carry_d;
      if (state_q == IDU_IDLE && idu_req) begin
        wb_sel   <= idu_sel;
        dec_q    <= idu_dec;
        idu_addr <= pair_val_c;
      end
    end
  end

endmodule

// File: rtl/regfile_pair_idu.sv
// Byte register file organised as 16-bit pairs, with byte/pair write ports,
// combinational read ports and an integrated pair increment/decrement unit.
// Optional build macro REGFILE_BYPASS_EN forwards same-cycle wr/pw data to reads.
module regfile_pair_idu
  import regfile_pkg::*;
#(
  parameter int unsigned    DW        = 8,
  parameter int unsigned    NREGS     = 8,
  parameter int unsigned    NRD       = 2,
  parameter logic [DW-1:0]  RESET_VAL = '0,
  parameter int unsigned    IDU_SPLIT = 1,
  localparam int unsigned   AW        = $clog2(NREGS),
  localparam int unsigned   PAW       = $clog2(NREGS / 2),
  localparam int unsigned   PW        = 2 * DW
) (
  input  logic              CLK,
  input  logic              nres,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_sel,
  input  logic [DW-1:0]     wr_data,
  input  logic              pw_en,
  input  logic [PAW-1:0]    pw_sel,
  input  logic [PW-1:0]     pw_data,
  input  logic [NRD*AW-1:0] rd_sel,
  output logic [NRD*DW-1:0] rd_data,
  input  logic              idu_req,
  input  logic [PAW-1:0]    idu_sel,
  input  logic              idu_dec,
  output logic              idu_busy,
  output logic              idu_done,
  output logic [PW-1:0]     idu_addr,
  output logic              idu_wrap
);

  logic [DW-1:0]    regs [NREGS];
  logic [NREGS-1:0] ext_we_c;
  logic [DW-1:0]    ext_data_c [NREGS];
  logic [NREGS-1:0] idu_we_c;
  logic [DW-1:0]    idu_data_c [NREGS];
  logic [PW-1:0]    idu_pair_c;
  logic [PAW-1:0]   wb_sel;
  logic             hi_we_c, lo_we_c;
  logic [DW-1:0]    hi_data_c, lo_data_c;

  regfile_idu_fsm #(
    .DW        (DW),
    .PAW       (PAW),
    .IDU_SPLIT (IDU_SPLIT)
  ) u_idu (
    .clk        (CLK),
    .nres       (nres),
    .idu_req    (idu_req),
    .idu_sel    (idu_sel),
    .idu_dec    (idu_dec),
    .pair_val_c (idu_pair_c),
    .idu_busy   (idu_busy),
    .idu_done   (idu_done),
    .idu_addr   (idu_addr),
    .idu_wrap   (idu_wrap),
    .wb_sel     (wb_sel),
    .hi_we_c    (hi_we_c),
    .lo_we_c    (lo_we_c),
    .hi_data_c  (hi_data_c),
    .lo_data_c  (lo_data_c)
  );

  // External write decode per register; pair write overrides byte write.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      ext_we_c[i]   = 1'b0;
      ext_data_c[i] = '0;
      if (wr_en && wr_sel == AW'(i)) begin
        ext_we_c[i]   = 1'b1;
        ext_data_c[i] = wr_data;
      end
      if (pw_en && pw_sel == PAW'(i / 2)) begin
        ext_we_c[i]   = 1'b1;
        ext_data_c[i] = (hi_idx(i / 2) == i) ? pw_data[PW-1:DW] : pw_data[DW-1:0];
      end
    end
  end

  // IDU writeback decode per register.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      idu_we_c[i]   = (wb_sel == PAW'(i / 2)) &&
                      ((hi_we_c && hi_idx(i / 2) == i) || (lo_we_c && lo_idx(i / 2) == i));
      idu_data_c[i] = (hi_idx(i / 2) == i) ? hi_data_c : lo_data_c;
    end
  end

  // Current value of the pair addressed by an incoming IDU request.
  always_comb begin
    idu_pair_c = '0;
    for (int unsigned p = 0; p < NREGS / 2; p++) begin
      if (idu_sel == PAW'(p)) idu_pair_c = {regs[hi_idx(p)], regs[lo_idx(p)]};
    end
  end

  // Register array update: reset, then IDU writeback, then external writes.
  always_ff @(posedge CLK) begin
    if (!nres) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (idu_we_c[i])      regs[i] <= idu_data_c[i];
        else if (ext_we_c[i]) regs[i] <= ext_data_c[i];
      end
    end
  end

  // Read muxes; an index with no matching register reads as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      for (int unsigned j = 0; j < NREGS; j++) begin
        if (rd_sel[k*AW +: AW] == AW'(j)) begin
`ifdef REGFILE_BYPASS_EN
          rd_data[k*DW +: DW] = ext_we_c[j] ? ext_data_c[j] : regs[j];
`else
          rd_data[k*DW +: DW] = regs[j];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_pair_idu.sv
// Self-checking bench for regfile_pair_idu (default parameters, byte-serial IDU).
module tb_regfile_pair_idu;
  import regfile_pkg::*;

  localparam int unsigned DW = 8, NREGS = 8, NRD = 2, AW = 3, PAW = 2, PW = 16;

  logic              CLK = 1'b0;
  logic              nres;
  logic              wr_en;
  logic [AW-1:0]     wr_sel;
  logic [DW-1:0]     wr_data;
  logic              pw_en;
  logic [PAW-1:0]    pw_sel;
  logic [PW-1:0]     pw_data;
  logic [NRD*AW-1:0] rd_sel;
  logic [NRD*DW-1:0] rd_data;
  logic              idu_req;
  logic [PAW-1:0]    idu_sel;
  logic              idu_dec;
  logic              idu_busy, idu_done, idu_wrap;
  logic [PW-1:0]     idu_addr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] model [NREGS];

  regfile_pair_idu dut (
    .CLK(CLK), .nres(nres),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .pw_en(pw_en), .pw_sel(pw_sel), .pw_data(pw_data),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .idu_req(idu_req), .idu_sel(idu_sel), .idu_dec(idu_dec),
    .idu_busy(idu_busy), .idu_done(idu_done), .idu_addr(idu_addr), .idu_wrap(idu_wrap)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_sel = '0; wr_data = '0;
    pw_en = 0; pw_sel = '0; pw_data = '0;
    idu_req = 0; idu_sel = '0; idu_dec = 0;
    rd_sel = '0;
  endtask

  task automatic write_byte(input int idx, input logic [7:0] v);
    wr_en = 1; wr_sel = AW'(idx); wr_data = v;
    step();
    wr_en = 0;
    model[idx] = v;
  endtask

  task automatic write_pair(input int p, input logic [15:0] v);
    pw_en = 1; pw_sel = PAW'(p); pw_data = v;
    step();
    pw_en = 0;
    model[2*p] = v[15:8];
    model[2*p+1] = v[7:0];
  endtask

  // Port 0 reads the high byte, port 1 the low byte.
  task automatic get_pair(input int p, output logic [15:0] v);
    rd_sel = {AW'(2*p+1), AW'(2*p)};
    #1;
    v = {rd_data[7:0], rd_data[15:8]};
  endtask

  task automatic run_idu(input int p, input logic dec, output bit seen);
    idu_sel = PAW'(p); idu_dec = dec; idu_req = 1;
    step();
    idu_req = 0;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (idu_done) seen = 1;
      step();
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    for (int i = 0; i < NREGS; i++) write_byte(i, 8'h5A);
    // start an IDU op, then reset during it
    idu_sel = 2'd0; idu_dec = 0; idu_req = 1;
    step();
    idu_req = 0;
    nres = 0;
    step();
    nres = 1;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    for (int p = 0; p < NREGS / 2; p++) begin
      get_pair(p, v);
      n_cmp++;
      if (v !== 16'h0000) begin
        n_bad++; $display("FAIL reset_pair%0d got=%h exp=0000", p, v);
      end
    end
    n_cmp++;
    if ({idu_busy, idu_done, idu_wrap} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=000", {idu_busy, idu_done, idu_wrap});
    end
    n_cmp++;
    if (idu_addr !== 16'h0000) begin
      n_bad++; $display("FAIL reset_addr got=%h exp=0000", idu_addr);
    end
  endtask

  task automatic test_priority();
    logic [15:0] v;
    wr_en = 1; wr_sel = 3'd2; wr_data = 8'h11;
    pw_en = 1; pw_sel = 2'd1; pw_data = 16'h2233;
    step();
    wr_en = 0; pw_en = 0;
    model[2] = 8'h22; model[3] = 8'h33;
    get_pair(1, v);
    n_cmp++;
    if (v !== 16'h2233) begin
      n_bad++; $display("FAIL priority_pw_over_wr got=%h exp=2233", v);
    end
    // non-colliding byte and pair writes land together
    wr_en = 1; wr_sel = 3'd0; wr_data = 8'h44;
    pw_en = 1; pw_sel = 2'd2; pw_data = 16'h5566;
    step();
    wr_en = 0; pw_en = 0;
    model[0] = 8'h44; model[4] = 8'h55; model[5] = 8'h66;
    get_pair(2, v);
    n_cmp++;
    if (v !== 16'h5566) begin
      n_bad++; $display("FAIL parallel_pw got=%h exp=5566", v);
    end
    rd_sel = {AW'(1), AW'(0)};
    #1;
    n_cmp++;
    if (rd_data[7:0] !== 8'h44) begin
      n_bad++; $display("FAIL parallel_wr got=%h exp=44", rd_data[7:0]);
    end
  endtask

  task automatic test_idu_inc();
    logic [15:0] v;
    write_pair(2, 16'h12FF);
    idu_sel = 2'd2; idu_dec = 0; idu_req = 1;
    step();
    idu_req = 0;
    n_cmp++;
    if ({idu_busy, idu_done} !== 2'b10 || idu_addr !== 16'h12FF) begin
      n_bad++; $display("FAIL inc_first_cycle got busy/done=%b addr=%h exp=10 12ff", {idu_busy, idu_done}, idu_addr);
    end
    step();
    n_cmp++;
    if ({idu_busy, idu_done} !== 2'b11) begin
      n_bad++; $display("FAIL inc_done_cycle got=%b exp=11", {idu_busy, idu_done});
    end
    step();
    n_cmp++;
    if ({idu_busy, idu_done, idu_wrap} !== 3'b000) begin
      n_bad++; $display("FAIL inc_after got busy/done/wrap=%b exp=000", {idu_busy, idu_done, idu_wrap});
    end
    get_pair(2, v);
    n_cmp++;
    if (v !== 16'h1300) begin
      n_bad++; $display("FAIL inc_result got=%h exp=1300", v);
    end
    model[4] = 8'h13; model[5] = 8'h00;
  endtask

  task automatic test_wrap();
    logic [15:0] v;
    bit seen;
    write_pair(0, 16'h0000);
    run_idu(0, 1'b1, seen);
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL wrap_dec_timeout got=0 exp=1");
    end
    get_pair(0, v);
    n_cmp++;
    if (v !== 16'hFFFF || idu_wrap !== 1'b1) begin
      n_bad++; $display("FAIL wrap_dec got=%h wrap=%b exp=ffff 1", v, idu_wrap);
    end
    run_idu(0, 1'b0, seen);
    get_pair(0, v);
    n_cmp++;
    if (!seen || v !== 16'h0000 || idu_wrap !== 1'b1 || idu_addr !== 16'hFFFF) begin
      n_bad++; $display("FAIL wrap_inc got=%h wrap=%b addr=%h seen=%b exp=0000 1 ffff 1", v, idu_wrap, idu_addr, seen);
    end
    model[0] = 8'h00; model[1] = 8'h00;
  endtask

  task automatic test_collision();
    logic [15:0] v;
    write_pair(3, 16'hBEEF);
    // external write to hi byte during LO: IDU hi writeback wins
    write_pair(1, 16'h00FF);
    idu_sel = 2'd1; idu_dec = 0; idu_req = 1;
    step();
    idu_req = 0;
    wr_en = 1; wr_sel = 3'd2; wr_data = 8'hAA;
    step();
    wr_en = 0;
    step();
    get_pair(1, v);
    n_cmp++;
    if (v !== 16'h0100) begin
      n_bad++; $display("FAIL collide_hi got=%h exp=0100", v);
    end
    // external write to lo byte during HI stays; request during HI is dropped
    write_pair(1, 16'h00FF);
    idu_sel = 2'd1; idu_dec = 0; idu_req = 1;
    step();
    idu_req = 0;
    step();
    wr_en = 1; wr_sel = 3'd3; wr_data = 8'h5C;
    idu_req = 1; idu_sel = 2'd3; idu_dec = 1;
    n_cmp++;
    if (idu_done !== 1'b1) begin
      n_bad++; $display("FAIL collide_done got=%b exp=1", idu_done);
    end
    step();
    wr_en = 0; idu_req = 0;
    n_cmp++;
    if (idu_busy !== 1'b0) begin
      n_bad++; $display("FAIL req_in_hi_accepted got busy=%b exp=0", idu_busy);
    end
    get_pair(1, v);
    n_cmp++;
    if (v !== 16'h015C || idu_addr !== 16'h00FF) begin
      n_bad++; $display("FAIL collide_lo got=%h addr=%h exp=015c 00ff", v, idu_addr);
    end
    model[2] = 8'h01; model[3] = 8'h5C;
    step(); step();
    get_pair(3, v);
    n_cmp++;
    if (v !== 16'hBEEF) begin
      n_bad++; $display("FAIL ignored_req_pair got=%h exp=beef", v);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] e0, e1;
    write_byte(5, 8'h10);
    wr_en = 1; wr_sel = 3'd5; wr_data = 8'h77;
    rd_sel = {AW'(0), AW'(5)};
    #1;
`ifdef REGFILE_BYPASS_EN
    e0 = 8'h77;
`else
    e0 = 8'h10;
`endif
    n_cmp++;
    if (rd_data[7:0] !== e0) begin
      n_bad++; $display("FAIL bypass_same_cycle got=%h exp=%h", rd_data[7:0], e0);
    end
    step();
    wr_en = 0;
    model[5] = 8'h77;
    #1;
    n_cmp++;
    if (rd_data[7:0] !== 8'h77) begin
      n_bad++; $display("FAIL bypass_next_cycle got=%h exp=77", rd_data[7:0]);
    end
    // pair write forwarding beats byte write forwarding
    wr_en = 1; wr_sel = 3'd4; wr_data = 8'h99;
    pw_en = 1; pw_sel = 2'd2; pw_data = 16'hABCD;
    rd_sel = {AW'(5), AW'(4)};
    #1;
`ifdef REGFILE_BYPASS_EN
    e0 = 8'hAB; e1 = 8'hCD;
`else
    e0 = model[4]; e1 = model[5];
`endif
    n_cmp++;
    if (rd_data !== {e1, e0}) begin
      n_bad++; $display("FAIL bypass_pair got=%h exp=%h", rd_data, {e1, e0});
    end
    step();
    wr_en = 0; pw_en = 0;
    model[4] = 8'hAB; model[5] = 8'hCD;
  endtask

  task automatic test_random();
    logic [7:0] exp_rd [NRD];
    logic [15:0] v, pv, ev;
    int idx, p;
    bit dec, seen, wrap_exp;
    for (int it = 0; it < 200; it++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_sel = AW'($urandom_range(0, NREGS - 1));
      wr_data = 8'($urandom);
      pw_en = 1'($urandom_range(0, 1));
      pw_sel = PAW'($urandom_range(0, NREGS / 2 - 1));
      pw_data = 16'($urandom);
      for (int k = 0; k < NRD; k++) begin
        idx = $urandom_range(0, NREGS - 1);
        rd_sel[k*AW +: AW] = AW'(idx);
        exp_rd[k] = model[idx];
`ifdef REGFILE_BYPASS_EN
        if (pw_en && int'(pw_sel) == idx / 2) exp_rd[k] = (idx % 2 == 0) ? pw_data[15:8] : pw_data[7:0];
        else if (wr_en && int'(wr_sel) == idx) exp_rd[k] = wr_data;
`endif
      end
      #1;
      for (int k = 0; k < NRD; k++) begin
        n_cmp++;
        if (rd_data[k*DW +: DW] !== exp_rd[k]) begin
          n_bad++; $display("FAIL rand_read it=%0d port=%0d got=%h exp=%h", it, k, rd_data[k*DW +: DW], exp_rd[k]);
        end
      end
      step();
      if (wr_en) model[wr_sel] = wr_data;
      if (pw_en) begin
        model[2*pw_sel] = pw_data[15:8];
        model[2*pw_sel+1] = pw_data[7:0];
      end
      wr_en = 0; pw_en = 0;
      if (it % 20 == 19) begin
        p = $urandom_range(0, NREGS / 2 - 1);
        dec = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: pv = 16'h0000;
          1: pv = 16'hFFFF;
          default: pv = 16'($urandom);
        endcase
        write_pair(p, pv);
        run_idu(p, dec, seen);
        if (dec) ev = 16'((32'(pv) + IDU_WRAP_MAX) & IDU_WRAP_MAX);
        else     ev = 16'((32'(pv) + 1) & IDU_WRAP_MAX);
        wrap_exp = dec ? (pv == 16'h0000) : (pv == 16'hFFFF);
        get_pair(p, v);
        n_cmp++;
        if (!seen || v !== ev || idu_wrap !== wrap_exp || idu_addr !== pv) begin
          n_bad++; $display("FAIL rand_idu pair=%0d dec=%b got=%h wrap=%b addr=%h seen=%b exp=%h %b %h 1", p, dec, v, idu_wrap, idu_addr, seen, ev, wrap_exp, pv);
        end
        model[2*p] = ev[15:8];
        model[2*p+1] = ev[7:0];
      end
    end
  endtask

  initial begin
    idle_inputs();
    nres = 0;
    step(); step();
    nres = 1;
    step();
    test_reset();
    test_priority();
    test_idu_inc();
    test_wrap();
    test_collision();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
